// File: rtl/mskaes_mc_serial_pkg.sv
// Shared definitions for the masked MixColumns unit: GF(2^8) helpers and
// share (de)interleaving for masked bytes (bit i of share j at index i*d+j).
package mskaes_mc_serial_pkg;

  localparam logic [7:0] AES_RED = 8'h1b;
  localparam int MAX_D = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_t;

  function automatic int mbw(input int d);
    return 8 * d;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_RED : 8'h00);
  endfunction

  // Masked bytes travel zero-extended to MAX_D shares so one signature serves every d.
  function automatic logic [7:0] get_share(input logic [8*MAX_D-1:0] mb,
                                           input int d, input int j);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = mb[i*d+j];
    return b;
  endfunction

  function automatic logic [8*MAX_D-1:0] set_share(input logic [8*MAX_D-1:0] mb,
                                                   input int d, input int j,
                                                   input logic [7:0] b);
    logic [8*MAX_D-1:0] r;
    r = mb;
    for (int i = 0; i < 8; i++) r[i*d+j] = b[i];
    return r;
  endfunction

endpackage

// File: rtl/mskaes_mc_column.sv
// Combinational MixColumns of one masked column, applied share by share.
module mskaes_mc_column
  import mskaes_mc_serial_pkg::*;
#(
  parameter int d = 2
) (
  input  logic [32*d-1:0] col_in,
  output logic [32*d-1:0] col_out
);

  localparam int MBW = mbw(d);

  logic [8*MAX_D-1:0] tmp;
  logic [3:0][7:0]    a;
  logic [3:0][7:0]    b;

  // Each share is pulled out, transformed on its own and written back to its
  // own bit positions, so no two shares ever meet in an XOR.
  always_comb begin
    col_out = '0;
    tmp     = '0;
    a       = '0;
    b       = '0;
    for (int s = 0; s < d; s++) begin
      for (int r = 0; r < 4; r++) begin
        tmp = '0;
        tmp[MBW-1:0] = col_in[r*MBW +: MBW];
        a[r] = get_share(tmp, d, s);
      end
      b[0] = xtime(a[0]) ^ xtime(a[1]) ^ a[1] ^ a[2] ^ a[3];
      b[1] = a[0] ^ xtime(a[1]) ^ xtime(a[2]) ^ a[2] ^ a[3];
      b[2] = a[0] ^ a[1] ^ xtime(a[2]) ^ xtime(a[3]) ^ a[3];
      b[3] = xtime(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xtime(a[3]);
      for (int r = 0; r < 4; r++) begin
        tmp = '0;
        tmp[MBW-1:0] = col_out[r*MBW +: MBW];
        tmp = set_share(tmp, d, s, b[r]);
        col_out[r*MBW +: MBW] = tmp[MBW-1:0];
      end
    end
  end

endmodule

// File: rtl/mskaes_mc_serial.sv
// Masked forward AES MixColumns, one column per cycle over a valid/ready handshake.
module mskaes_mc_serial
  import mskaes_mc_serial_pkg::*;
#(
  parameter int d = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [128*d-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [128*d-1:0] out_data
);

  localparam int CW = 32 * d;

  mc_state_t        state;
  logic [1:0]       col;
  logic [128*d-1:0] st;
  logic [CW-1:0]    col_in;
  logic [CW-1:0]    col_out;

  assign col_in    = st[CW*int'(col) +: CW];
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = st;

  mskaes_mc_column #(.d(d)) u_column (
    .col_in  (col_in),
    .col_out (col_out)
  );

  // The column counter wraps back to 0 on the last column, ready for the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      col   <= 2'd0;
      st    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            st    <= in_data;
            col   <= 2'd0;
            state <= BUSY;
          end
        end
        BUSY: begin
          st[CW*int'(col) +: CW] <= col_out;
          col <= col + 2'd1;
          if (col == 2'd3) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mskaes_mc_serial.sv
// Self-checking bench for mskaes_mc_serial: table vectors, random masks, corner sequences.
module tb_mskaes_mc_serial;

  logic clk = 1'b0;
  logic rst;

  logic         in_valid2, in_ready2, out_valid2, out_ready2;
  logic [255:0] in_data2, out_data2;
  logic         in_valid1, in_ready1, out_valid1, out_ready1;
  logic [127:0] in_data1, out_data1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mskaes_mc_serial #(.d(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .in_data   (in_data2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .out_data  (out_data2)
  );

  mskaes_mc_serial #(.d(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_data   (in_data1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_data  (out_data1)
  );

  typedef struct {
    logic [127:0] x;
    logic [127:0] m;
    logic [127:0] exp;
  } vec_t;

  // Reference model: general GF(2^8) multiply and the MixColumns matrix product.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int p = 0;
    int x = int'(a);
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x << 1;
      if ((x & 'h100) != 0) x = x ^ 'h11b;
    end
    return p[7:0];
  endfunction

  function automatic logic [127:0] mc_state(input logic [127:0] s);
    logic [7:0] coef [4] = '{8'd2, 8'd3, 8'd1, 8'd1};
    logic [127:0] o = '0;
    logic [7:0] acc;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(coef[(k - r + 4) % 4], s[8*(4*c+k) +: 8]);
        o[8*(4*c+r) +: 8] = acc;
      end
    return o;
  endfunction

  // Column words are written a0 first (most significant hex digits), as in the AES texts.
  function automatic logic [127:0] cols2state(input logic [31:0] c0, input logic [31:0] c1,
                                              input logic [31:0] c2, input logic [31:0] c3);
    logic [31:0] cw [4];
    logic [127:0] s = '0;
    cw[0] = c0; cw[1] = c1; cw[2] = c2; cw[3] = c3;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[8*(4*c+r) +: 8] = cw[c][31-8*r -: 8];
    return s;
  endfunction

  function automatic logic [255:0] pack2(input logic [127:0] s0, input logic [127:0] s1);
    logic [255:0] r = '0;
    for (int k = 0; k < 16; k++)
      for (int i = 0; i < 8; i++) begin
        r[16*k + 2*i]     = s0[8*k + i];
        r[16*k + 2*i + 1] = s1[8*k + i];
      end
    return r;
  endfunction

  function automatic logic [127:0] share_of(input logic [255:0] v, input int j);
    logic [127:0] r = '0;
    for (int k = 0; k < 16; k++)
      for (int i = 0; i < 8; i++)
        r[8*k + i] = v[16*k + 2*i + j];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [255:0] din, input bit release_out,
                               output logic [255:0] dout, output int lat);
    int w = 0;
    @(negedge clk);
    while (!in_ready2 && w < 20) begin
      @(negedge clk);
      w++;
    end
    in_valid2 = 1'b1;
    in_data2 = din;
    out_ready2 = 1'b0;
    @(posedge clk);
    #1 in_valid2 = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid2 && lat < 20);
    dout = out_data2;
    if (release_out) begin
      out_ready2 = 1'b1;
      @(negedge clk);
      out_ready2 = 1'b0;
    end
  endtask

  task automatic applyStimulus1(input logic [127:0] din, output logic [127:0] dout,
                                output int lat);
    int w = 0;
    @(negedge clk);
    while (!in_ready1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    in_valid1 = 1'b1;
    in_data1 = din;
    out_ready1 = 1'b0;
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid1 && lat < 20);
    dout = out_data1;
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
  endtask

  initial begin
    vec_t vt2 [10];
    vec_t vt1 [4];
    logic [127:0] x1, e1, xc, ec;
    logic [255:0] res, hold;
    logic [127:0] res1;
    logic [127:0] sx [3];
    logic [127:0] sm [3];
    logic [255:0] outs [$];
    int acc_t [3];
    int lat, nacc;
    bit accepted;

    x1 = cols2state(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hd4d4d4d5);
    e1 = cols2state(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hd5d5d7d6);
    vt2[0] = '{x: x1, m: 128'h0, exp: e1};
    vt2[1] = '{x: x1, m: rand128(), exp: e1};
    for (int i = 2; i < 10; i++) begin
      vt2[i].x = rand128();
      vt2[i].m = rand128();
      vt2[i].exp = mc_state(vt2[i].x);
    end
    vt1[0] = '{x: cols2state(32'hc6c6c6c6, 32'h2d26314c, 32'hdb135345, 32'h01010101),
               m: 128'h0,
               exp: cols2state(32'hc6c6c6c6, 32'h4d7ebdf8, 32'h8e4da1bc, 32'h01010101)};
    for (int i = 1; i < 4; i++) begin
      vt1[i].x = rand128();
      vt1[i].m = 128'h0;
      vt1[i].exp = mc_state(vt1[i].x);
    end

    rst = 1'b1;
    in_valid2 = 1'b0; out_ready2 = 1'b0; in_data2 = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; in_data1 = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_in_ready", 256'(in_ready2), 256'(1));
    checkOutput("reset_out_valid", 256'(out_valid2), 256'(0));
    checkOutput("reset_out_data", out_data2, 256'h0);
    rst = 1'b0;

    // Table vectors with d=2: recombined result and each share on its own.
    foreach (vt2[i]) begin
      applyStimulus(pack2(vt2[i].m, vt2[i].x ^ vt2[i].m), 1'b1, res, lat);
      checkOutput($sformatf("latency_%0d", i), 256'(lat), 256'(5));
      checkOutput($sformatf("recombined_%0d", i), 256'(share_of(res, 0) ^ share_of(res, 1)),
                  256'(vt2[i].exp));
      checkOutput($sformatf("share0_%0d", i), 256'(share_of(res, 0)), 256'(mc_state(vt2[i].m)));
      checkOutput($sformatf("share1_%0d", i), 256'(share_of(res, 1)),
                  256'(mc_state(vt2[i].x ^ vt2[i].m)));
    end

    // Backpressure: output held stable, a pulsed input is ignored.
    xc = rand128();
    sm[0] = rand128();
    applyStimulus(pack2(sm[0], xc ^ sm[0]), 1'b0, hold, lat);
    checkOutput("bp_value", 256'(share_of(hold, 0) ^ share_of(hold, 1)), 256'(mc_state(xc)));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid2 = (i == 3);
      in_data2 = ~hold;
      checkOutput($sformatf("bp_valid_%0d", i), 256'(out_valid2), 256'(1));
      checkOutput($sformatf("bp_data_%0d", i), out_data2, hold);
      checkOutput($sformatf("bp_in_ready_%0d", i), 256'(in_ready2), 256'(0));
    end
    @(negedge clk);
    in_valid2 = 1'b0;
    out_ready2 = 1'b1;
    @(negedge clk);
    out_ready2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_no_accept_%0d", i), 256'(out_valid2), 256'(0));
    end

    // Asynchronous reset in the middle of BUSY discards the transaction.
    @(negedge clk);
    in_valid2 = 1'b1;
    in_data2 = pack2(rand128(), rand128());
    @(posedge clk);
    #1 in_valid2 = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("rst_in_ready", 256'(in_ready2), 256'(1));
    checkOutput("rst_out_valid", 256'(out_valid2), 256'(0));
    checkOutput("rst_out_data", out_data2, 256'h0);
    @(negedge clk);
    rst = 1'b0;
    xc = cols2state(32'h2d26314c, 32'h2d26314c, 32'h2d26314c, 32'h2d26314c);
    ec = cols2state(32'h4d7ebdf8, 32'h4d7ebdf8, 32'h4d7ebdf8, 32'h4d7ebdf8);
    sm[0] = rand128();
    applyStimulus(pack2(sm[0], xc ^ sm[0]), 1'b1, res, lat);
    checkOutput("post_rst_latency", 256'(lat), 256'(5));
    checkOutput("post_rst_value", 256'(share_of(res, 0) ^ share_of(res, 1)), 256'(ec));

    // Streaming with in_valid and out_ready held high.
    for (int i = 0; i < 3; i++) begin
      sx[i] = rand128();
      sm[i] = rand128();
    end
    @(negedge clk);
    nacc = 0;
    in_valid2 = 1'b1;
    out_ready2 = 1'b1;
    in_data2 = pack2(sm[0], sx[0] ^ sm[0]);
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (cyc > 0) @(negedge clk);
      accepted = in_valid2 && in_ready2;
      if (accepted) begin
        acc_t[nacc] = cyc;
        nacc++;
      end
      if (out_valid2) outs.push_back(out_data2);
      if (outs.size() == 3 && nacc == 3) break;
      @(posedge clk);
      #1;
      if (accepted) begin
        if (nacc < 3) in_data2 = pack2(sm[nacc], sx[nacc] ^ sm[nacc]);
        else in_valid2 = 1'b0;
      end
    end
    in_valid2 = 1'b0;
    out_ready2 = 1'b0;
    checkOutput("stream_accepts", 256'(nacc), 256'(3));
    checkOutput("stream_results", 256'(outs.size()), 256'(3));
    if (nacc == 3) begin
      checkOutput("stream_gap_0", 256'(acc_t[1] - acc_t[0]), 256'(6));
      checkOutput("stream_gap_1", 256'(acc_t[2] - acc_t[1]), 256'(6));
    end
    for (int i = 0; i < 3 && i < outs.size(); i++)
      checkOutput($sformatf("stream_out_%0d", i),
                  256'(share_of(outs[i], 0) ^ share_of(outs[i], 1)), 256'(mc_state(sx[i])));

    // Single-share instance.
    foreach (vt1[i]) begin
      applyStimulus1(vt1[i].x, res1, lat);
      checkOutput($sformatf("d1_latency_%0d", i), 256'(lat), 256'(5));
      checkOutput($sformatf("d1_value_%0d", i), 256'(res1), 256'(vt1[i].exp));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mskaes_mc_serial.md
Name: mskaes_mc_serial

Overview:
Masked forward AES MixColumns unit, the encrypt-direction counterpart of the inverse MixColumns datapath. It accepts a full d-share masked 128-bit state over a valid/ready handshake and applies MixColumns one column per cycle, share by share. It then presents the result on a valid/ready output. MixColumns is GF(2)-linear, so no fresh randomness is used. Shares are never combined.

Parameters:
d, 2, number of shares (d >= 1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  input state valid
in_ready  output  1  block can accept a state
in_data  input  128*d  masked input state
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  128*d  masked MixColumns result

Behaviour:
- Encoding of one masked byte (8*d bits): bit i of share j sits at index i*d+j.
- State byte k occupies [8*d*k +: 8*d]. AES column-major order: column c = bytes 4c..4c+3, row r = byte 4c+r.
- Per column, per share s (all arithmetic in GF(2^8), poly 0x11b):
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00); 3x = xtime(x)^x.
- FSM states: IDLE, BUSY, DONE. Column counter col is 2 bits.
- Combinational outputs: in_ready = (state==IDLE); out_valid = (state==DONE); out_data = state register.
- IDLE: on in_valid&in_ready, load in_data into the state register, set col=0, go to BUSY.
- BUSY: each cycle, replace column col in place with its MixColumns result and increment col.
  - When col==3, finish the update and go to DONE. col wraps to 0.
- DONE: hold the state register. When out_ready is high, go to IDLE.
  - in_ready stays 0 in DONE, so no same-cycle accept.
- Latency: accept in cycle T, out_valid high from cycle T+5. Minimum spacing between accepts is 6 cycles.
- Backpressure: while out_valid & !out_ready, out_data is bit-stable. in_valid and in_data are ignored outside IDLE.
- Reset, asynchronous, any time (including mid-BUSY or in DONE):
  - state=IDLE, col=0, state register=0.
  - Outputs: in_ready=1, out_valid=0, out_data=0.
  - Any in-flight transaction is discarded.
- Sharewise isolation: output share j is a function of input share j only. No logic may XOR different shares together.

Decomposition:
- Shared package:
  - AES reduction constant 8'h1b.
  - Masked byte width function (8*d).
  - Function extracting share j of a masked byte and its inverse (re-interleave).
- Sub-module mskaes_mc_column: combinational, parameter d, 4 masked bytes in and 4 out. Instantiates a per-share xtime.
- Top: FSM, counter, 128*d state register, column mux/demux.

Test Plan:
1. d=2, share0=0 and share1=value, state columns db135345, f20a225c, 01010101, d4d4d4d5 -> recombined out = 8e4da1bc, 9fdc589d, 01010101, d5d5d7d6. out_valid first high exactly 5 cycles after accept.
2. d=2, random mask R with share0=R and share1=X^R, X from scenario 1 -> XOR of output shares equals scenario 1 results. Each output share equals MixColumns(R) and MixColumns(X^R) respectively.
3. Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_valid stays 1, out_data unchanged, in_ready=0. A pulsed in_valid with different data is not accepted.
4. Assert rst in cycle T+2 of a transaction -> immediately in_ready=1, out_valid=0, out_data=0. The next transaction with column 2d26314c gives 4d7ebdf8.
5. Streaming: in_valid and out_ready held at 1 with 3 states queued -> accepts spaced exactly 6 cycles apart, 3 results in order, none dropped or duplicated.
6. d=1: columns c6c6c6c6, 2d26314c, db135345, 01010101 -> c6c6c6c6, 4d7ebdf8, 8e4da1bc, 01010101.
